// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares one data-memory port between the pipeline LSU and an
//               external requester. Each access is latched, held on the
//               memory port until mem_ready (or timeout), then answered with
//               a one-cycle ack to the winning requester.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int TIMEOUT    = 255,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // LSU requester
  input  logic        lsu_req,
  input  logic [31:0] lsu_addr,
  input  logic [3:0]  lsu_we,
  input  logic [31:0] lsu_wdata,
  output logic [31:0] lsu_rdata,
  output logic        lsu_ack,
  output logic        lsu_err,
  // External requester
  input  logic        ext_req,
  input  logic [31:0] ext_addr,
  input  logic [3:0]  ext_we,
  input  logic [31:0] ext_wdata,
  output logic [31:0] ext_rdata,
  output logic        ext_ack,
  output logic        ext_err,
  // Memory port
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  // Pipeline stall
  output logic        stall_o
);

  localparam int c_TMO_W = $clog2(TIMEOUT + 1);
  localparam int c_STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
  localparam logic [c_STV_W-1:0] c_STV_MAX  = c_STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_owner_ext;
  logic [c_TMO_W-1:0]   r_tmo_cnt;
  logic [c_STV_W-1:0]   r_starve_cnt;
  logic                 r_mem_req;
  logic [31:0]          r_mem_addr;
  logic [3:0]           r_mem_we;
  logic [31:0]          r_mem_wdata;
  logic [31:0]          r_lsu_rdata;
  logic [31:0]          r_ext_rdata;
  logic                 r_lsu_ack;
  logic                 r_ext_ack;
  logic                 r_lsu_err;
  logic                 r_ext_err;

  logic                 w_any_req;
  logic                 w_pick_ext;
  logic                 w_timeout;
  logic [31:0]          w_rd_value;

  // Winner selection: LSU by default, ext when alone or when LSU has starved it
  assign w_any_req  = lsu_req | ext_req;
  assign w_pick_ext = ext_req & (~lsu_req | (r_starve_cnt == c_STV_MAX));
  assign w_timeout  = (r_tmo_cnt == c_TMO_LAST);
  // Writes return zero read data
  assign w_rd_value = (r_mem_we == 4'b0000) ? mem_rdata : 32'h0;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; ready takes precedence over a coincident timeout
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_next = S_BUSY;
      S_BUSY:  if (mem_ready || w_timeout) w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Access datapath: latch grant, time the wait, capture response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner_ext <= 1'b0;
      r_tmo_cnt   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_we    <= 4'h0;
      r_mem_wdata <= 32'h0;
      r_lsu_rdata <= 32'h0;
      r_ext_rdata <= 32'h0;
      r_lsu_ack   <= 1'b0;
      r_ext_ack   <= 1'b0;
      r_lsu_err   <= 1'b0;
      r_ext_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tmo_cnt <= '0;
          if (w_any_req) begin
            r_owner_ext <= w_pick_ext;
            r_mem_req   <= 1'b1;
            r_mem_addr  <= w_pick_ext ? ext_addr  : lsu_addr;
            r_mem_we    <= w_pick_ext ? ext_we    : lsu_we;
            r_mem_wdata <= w_pick_ext ? ext_wdata : lsu_wdata;
          end
        end
        S_BUSY: begin
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
          if (mem_ready || w_timeout) begin
            r_mem_req <= 1'b0;
            if (r_owner_ext) begin
              r_ext_rdata <= mem_ready ? w_rd_value : 32'h0;
              r_ext_ack   <= 1'b1;
              r_ext_err   <= ~mem_ready;
            end else begin
              r_lsu_rdata <= mem_ready ? w_rd_value : 32'h0;
              r_lsu_ack   <= 1'b1;
              r_lsu_err   <= ~mem_ready;
            end
          end
        end
        S_RESP: begin
          r_tmo_cnt <= '0;
          r_lsu_ack <= 1'b0;
          r_ext_ack <= 1'b0;
          r_lsu_err <= 1'b0;
          r_ext_err <= 1'b0;
        end
        default: r_mem_req <= 1'b0;
      endcase
    end
  end

  // Starvation counter: counts LSU grants that bypassed a pending ext request
  always_ff @(posedge clk) begin
    if (!rst_n || !ext_req) begin
      r_starve_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_pick_ext)
        r_starve_cnt <= '0;
      else if (r_starve_cnt != c_STV_MAX)
        r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign lsu_rdata = r_lsu_rdata;
  assign lsu_ack   = r_lsu_ack;
  assign lsu_err   = r_lsu_err;
  assign ext_rdata = r_ext_rdata;
  assign ext_ack   = r_ext_ack;
  assign ext_err   = r_ext_err;
  assign stall_o   = lsu_req & ~r_lsu_ack;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter (TIMEOUT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_req, ext_req, mem_ready;
  logic [31:0] lsu_addr, lsu_wdata, ext_addr, ext_wdata, mem_rdata;
  logic [3:0]  lsu_we, ext_we;
  logic [31:0] lsu_rdata, ext_rdata, mem_addr, mem_wdata;
  logic        lsu_ack, lsu_err, ext_ack, ext_err, mem_req, stall_o;
  logic [3:0]  mem_we;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.TIMEOUT(8), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_we(lsu_we), .lsu_wdata(lsu_wdata),
    .lsu_rdata(lsu_rdata), .lsu_ack(lsu_ack), .lsu_err(lsu_err),
    .ext_req(ext_req), .ext_addr(ext_addr), .ext_we(ext_we), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack), .ext_err(ext_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall_o(stall_o)
  );

  // Inputs change on the falling edge; outputs are sampled 1ns later
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lsu_req = 0; ext_req = 0; mem_ready = 0;
    lsu_addr = 0; lsu_wdata = 0; lsu_we = 0; ext_addr = 0; ext_wdata = 0; ext_we = 0;
    mem_rdata = 0;
    tick(); tick(); settle();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%0h exp=0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%0h exp=0", mem_addr); end
    checks++; if ({mem_we, mem_wdata} !== 36'h0) begin failures++; $display("FAIL reset_mem_we_wdata got=%0h exp=0", {mem_we, mem_wdata}); end
    checks++; if ({lsu_ack, lsu_err, ext_ack, ext_err} !== 4'b0) begin failures++; $display("FAIL reset_ack_err got=%b exp=0000", {lsu_ack, lsu_err, ext_ack, ext_err}); end
    checks++; if ({lsu_rdata, ext_rdata} !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", {lsu_rdata, ext_rdata}); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", stall_o); end
    tick(); rst_n = 1'b1;
  endtask

  task automatic test_lsu_read();
    tick(); lsu_req = 1; lsu_addr = 32'h100; lsu_we = 4'b0000; settle();      // cycle 0
    checks++; if ({stall_o, mem_req} !== 2'b10) begin failures++; $display("FAIL rd_c0 stall/mem_req got=%b exp=10", {stall_o, mem_req}); end
    tick(); mem_ready = 1; mem_rdata = 32'hDEADBEEF; settle();              // cycle 1
    checks++; if ({stall_o, mem_req, lsu_ack} !== 3'b110) begin failures++; $display("FAIL rd_c1 stall/mem_req/ack got=%b exp=110", {stall_o, mem_req, lsu_ack}); end
    checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL rd_c1 mem_addr got=%0h exp=100", mem_addr); end
    tick(); mem_ready = 0; settle();                                        // cycle 2
    checks++; if ({lsu_ack, lsu_err, stall_o, mem_req} !== 4'b1000) begin failures++; $display("FAIL rd_c2 ack/err/stall/mem_req got=%b exp=1000", {lsu_ack, lsu_err, stall_o, mem_req}); end
    checks++; if (lsu_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_c2 lsu_rdata got=%0h exp=deadbeef", lsu_rdata); end
    lsu_req = 0;
    tick(); settle();                                                       // cycle 3
    checks++; if ({lsu_ack, mem_req} !== 2'b00) begin failures++; $display("FAIL rd_c3 ack/mem_req got=%b exp=00", {lsu_ack, mem_req}); end
  endtask

  task automatic test_lsu_write();
    int acks = 0;
    int bad  = 0;
    tick(); lsu_req = 1; lsu_addr = 32'h200; lsu_we = 4'b0011; lsu_wdata = 32'h0000BEEF; settle();
    for (int c = 1; c <= 4; c++) begin
      tick(); mem_ready = (c == 4); mem_rdata = 32'h12345678; settle();
      if (mem_req !== 1'b1 || mem_we !== 4'b0011 || mem_wdata !== 32'h0000BEEF || mem_addr !== 32'h200) bad++;
      if (lsu_ack === 1'b1) acks++;
    end
    tick(); mem_ready = 0; settle();                                        // cycle 5
    checks++; if (bad !== 0) begin failures++; $display("FAIL wr_stable bad_cycles got=%0d exp=0", bad); end
    checks++; if ({lsu_ack, lsu_err} !== 2'b10) begin failures++; $display("FAIL wr_ack/err got=%b exp=10", {lsu_ack, lsu_err}); end
    checks++; if (lsu_rdata !== 32'h0) begin failures++; $display("FAIL wr_rdata got=%0h exp=0", lsu_rdata); end
    if (lsu_ack === 1'b1) acks++;
    lsu_req = 0; lsu_we = 0;
    for (int c = 6; c <= 7; c++) begin
      tick(); settle();
      if (lsu_ack === 1'b1) acks++;
    end
    checks++; if (acks !== 1) begin failures++; $display("FAIL wr_single_ack count got=%0d exp=1", acks); end
  endtask

  task automatic test_back_to_back();
    tick(); lsu_req = 1; lsu_addr = 32'h500; mem_ready = 1; mem_rdata = 32'h11112222; settle();
    for (int c = 1; c <= 5; c++) begin
      tick(); settle();
      checks++; if (lsu_ack !== ((c == 2) || (c == 5))) begin failures++; $display("FAIL b2b_ack cycle=%0d got=%0h exp=%0h", c, lsu_ack, (c == 2) || (c == 5)); end
      if (c == 5) lsu_req = 0;
    end
    mem_ready = 0;
  endtask

  task automatic test_starvation();
    logic [31:0] exp_addr;
    logic        prev = 1'b0;
    int g = 0, lack = 0, eack = 0;
    tick(); lsu_req = 1; ext_req = 1; lsu_addr = 32'hAAA0; ext_addr = 32'hEEE0;
    lsu_we = 0; ext_we = 0; mem_ready = 1; mem_rdata = 32'hCAFE0001; settle();
    for (int c = 0; c < 40 && g < 10; c++) begin
      tick(); settle();
      if (lsu_ack === 1'b1) lack++;
      if (ext_ack === 1'b1) eack++;
      if (mem_req === 1'b1 && !prev) begin
        exp_addr = ((g % 5) == 4) ? 32'hEEE0 : 32'hAAA0;
        checks++; if (mem_addr !== exp_addr) begin failures++; $display("FAIL starve_grant%0d addr got=%0h exp=%0h", g, mem_addr, exp_addr); end
        g++;
      end
      prev = mem_req;
    end
    lsu_req = 0; ext_req = 0;
    for (int c = 0; c < 4; c++) begin
      tick(); settle();
      if (lsu_ack === 1'b1) lack++;
      if (ext_ack === 1'b1) eack++;
    end
    checks++; if (g !== 10) begin failures++; $display("FAIL starve_grants count got=%0d exp=10", g); end
    checks++; if (lack !== 8 || eack !== 2) begin failures++; $display("FAIL starve_acks lsu/ext got=%0d/%0d exp=8/2", lack, eack); end
    mem_ready = 0;
  endtask

  task automatic test_timeout();
    int  reqc = 0, lack = 0;
    logic got = 1'b0;
    tick(); ext_req = 1; ext_addr = 32'h300; ext_we = 0; mem_ready = 0; settle();
    for (int c = 0; c < 20 && !got; c++) begin
      tick(); settle();
      if (lsu_ack === 1'b1) lack++;
      if (ext_ack === 1'b1) begin got = 1'b1; ext_req = 0; end
      else if (mem_req === 1'b1) reqc++;
    end
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL tmo_ack_seen got=%0h exp=1", got); end
    checks++; if (reqc !== 8) begin failures++; $display("FAIL tmo_mem_req_cycles got=%0d exp=8", reqc); end
    checks++; if ({ext_err, mem_req} !== 2'b10) begin failures++; $display("FAIL tmo_err/mem_req got=%b exp=10", {ext_err, mem_req}); end
    checks++; if (ext_rdata !== 32'h0) begin failures++; $display("FAIL tmo_ext_rdata got=%0h exp=0", ext_rdata); end
    checks++; if (lsu_rdata !== 32'hCAFE0001 || lack !== 0) begin failures++; $display("FAIL tmo_lsu_untouched rdata=%0h acks=%0d exp=cafe0001/0", lsu_rdata, lack); end
    tick(); settle();
  endtask

  task automatic test_ready_at_timeout();
    tick(); lsu_req = 1; lsu_addr = 32'h400; lsu_we = 0; settle();
    for (int c = 1; c <= 8; c++) begin
      tick(); mem_ready = (c == 8); mem_rdata = 32'h5A5A5A5A; settle();
    end
    tick(); mem_ready = 0; settle();
    checks++; if ({lsu_ack, lsu_err} !== 2'b10) begin failures++; $display("FAIL rdytmo_ack/err got=%b exp=10", {lsu_ack, lsu_err}); end
    checks++; if (lsu_rdata !== 32'h5A5A5A5A) begin failures++; $display("FAIL rdytmo_rdata got=%0h exp=5a5a5a5a", lsu_rdata); end
    lsu_req = 0;
    tick(); settle();
  endtask

  task automatic test_reset_mid_access();
    int acks = 0;
    tick(); lsu_req = 1; lsu_addr = 32'h600; mem_ready = 0; settle();   // cycle 0
    tick(); settle();                                                   // cycle 1
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_busy mem_req got=%0h exp=1", mem_req); end
    tick(); rst_n = 0; settle();                                        // cycle 2
    tick(); rst_n = 1; lsu_req = 0; settle();                           // cycle 3
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rstmid_mem_req got=%0h exp=0", mem_req); end
    checks++; if (lsu_rdata !== 32'h0) begin failures++; $display("FAIL rstmid_rdata got=%0h exp=0", lsu_rdata); end
    mem_ready = 1;
    for (int c = 0; c < 6; c++) begin
      tick(); settle();
      if (lsu_ack === 1'b1 || ext_ack === 1'b1 || mem_req === 1'b1) acks++;
    end
    checks++; if (acks !== 0) begin failures++; $display("FAIL rstmid_no_ack active_cycles got=%0d exp=0", acks); end
    mem_ready = 0;
  endtask

  initial begin
    test_reset();
    test_lsu_read();
    test_lsu_write();
    test_back_to_back();
    test_starvation();
    test_timeout();
    test_ready_at_timeout();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
